// File: rtl/tt_scan_pkg.sv
// Shared types and sizes for the 3-input truth-table scanner.
package tt_scan_pkg;
  localparam int N_IN   = 3;
  localparam int N_ROWS = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } tt_state_e;
endpackage

// File: rtl/tt_settle_timer.sv
// Settle-time counter: counts enabled cycles and flags the last settle cycle.
module tt_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == 4'(SETTLE - 1));
endmodule

// File: rtl/truth_table_scanner.sv
// Walks a 3-input gate through all 8 input vectors and captures its truth table.
// Optional golden-table comparison is enabled by defining TT_COMPARE_EN.
module truth_table_scanner
  import tt_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              a,
  output logic              b,
  output logic              c,
  input  logic              d,
  output logic              busy,
  output logic              done,
  output logic [N_ROWS-1:0] tt
`ifdef TT_COMPARE_EN
  ,
  input  logic [N_ROWS-1:0] expected,
  output logic              pass,
  output logic [N_ROWS-1:0] mismatch
`endif
);
  tt_state_e         state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [N_IN-1:0]   abc_q, abc_d;
  logic [N_ROWS-1:0] tt_q, tt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              expired;
  logic              last_sample;
`ifdef TT_COMPARE_EN
  logic [N_ROWS-1:0] expected_q, expected_d;
  logic [N_ROWS-1:0] mismatch_q, mismatch_d;
  logic              pass_q, pass_d;
`endif

  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != S_SETTLE),
    .enable  (state_q == S_SETTLE),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    abc_d       = abc_q;
    tt_d        = tt_q;
    last_sample = 1'b0;
    case (state_q)
      S_IDLE: begin
        abc_d = '0;
        if (start && !abort) begin
          state_d = S_SETTLE;
          idx_d   = '0;
          tt_d    = '0;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          abc_d   = '0;
        end else if (expired) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        // abort wins over capture, so the current bit is not written
        if (abort) begin
          state_d = S_IDLE;
          abc_d   = '0;
        end else begin
          tt_d[idx_q] = d;
          if (idx_q == N_IN'(N_ROWS - 1)) begin
            state_d     = S_DONE;
            last_sample = 1'b1;
          end else begin
            state_d = S_SETTLE;
            idx_d   = idx_q + 1'b1;
            abc_d   = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        abc_d   = '0;
      end
    endcase
    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

`ifdef TT_COMPARE_EN
  always_comb begin
    expected_d = expected_q;
    mismatch_d = mismatch_q;
    pass_d     = pass_q;
    if (state_q == S_IDLE && start && !abort) begin
      expected_d = expected;
      mismatch_d = '0;
      pass_d     = 1'b0;
    end else if (last_sample) begin
      mismatch_d = tt_d ^ expected_q;
      pass_d     = (tt_d == expected_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected_q <= '0;
      mismatch_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      expected_q <= expected_d;
      mismatch_q <= mismatch_d;
      pass_q     <= pass_d;
    end
  end

  assign pass     = pass_q;
  assign mismatch = mismatch_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      abc_q   <= '0;
      tt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abc_q   <= abc_d;
      tt_q    <= tt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a    = abc_q[2];
  assign b    = abc_q[1];
  assign c    = abc_q[0];
  assign busy = busy_q;
  assign done = done_q;
  assign tt   = tt_q;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (SETTLE=2 and SETTLE=1) scanning table-defined gates.
module tb_truth_table_scanner;
  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       a0, b0, c0, d0, busy0, done0;
  logic       a1, b1, c1, d1, busy1, done1;
  logic [7:0] tt0, tt1, tab0, tab1;
`ifdef TT_COMPARE_EN
  logic [7:0] exp0, exp1, mm0, mm1;
  logic       pass0, pass1;
`endif
  int checks = 0;
  int errors = 0;

  int busy_c[2], done_c[2], done_n[2];
  int hold_c[2][8];

  typedef struct {
    logic [7:0] t0;
    logic [7:0] t1;
    int         k;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  assign d0 = tab0[{a0, b0, c0}];
  assign d1 = tab1[{a1, b1, c1}];

  truth_table_scanner #(.SETTLE(2)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .tt(tt0)
`ifdef TT_COMPARE_EN
    , .expected(exp0), .pass(pass0), .mismatch(mm0)
`endif
  );

  truth_table_scanner #(.SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .tt(tt1)
`ifdef TT_COMPARE_EN
    , .expected(exp1), .pass(pass1), .mismatch(mm1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bits whose sample edge precedes the abort edge survive; no abort (or late abort) keeps all.
  function automatic logic [7:0] model_tt(input logic [7:0] tab, input int s, input int k);
    logic [7:0] m;
    int len;
    len = 8 * (s + 1);
    if (k == 0 || k > len) return tab;
    m = 8'h00;
    for (int i = 0; i < 8; i++)
      if ((i + 1) * (s + 1) < k) m[i] = 1'b1;
    return tab & m;
  endfunction

  // Start pulse, then observe 30 post-edge states; abort is sampled at accepting edge + k (k=0: none).
  task automatic run_scan(input int k);
    for (int i = 0; i < 2; i++) begin
      busy_c[i] = 0; done_c[i] = 0; done_n[i] = -1;
      for (int v = 0; v < 8; v++) hold_c[i][v] = 0;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (busy0) begin busy_c[0]++; hold_c[0][{a0, b0, c0}]++; end
      if (busy1) begin busy_c[1]++; hold_c[1][{a1, b1, c1}]++; end
      if (done0) begin done_c[0]++; if (done_n[0] < 0) done_n[0] = n; end
      if (done1) begin done_c[1]++; if (done_n[1] < 0) done_n[1] = n; end
      if (n == k - 1) abort = 1'b1;
      tick();
      abort = 1'b0;
    end
  endtask

  task automatic verify(input string tag, input int k, input logic [7:0] e0, input logic [7:0] e1);
    int s, len, bad;
    logic full;
    for (int i = 0; i < 2; i++) begin
      s    = (i == 0) ? 2 : 1;
      len  = 8 * (s + 1);
      full = (k == 0 || k > len);
      chk($sformatf("%s_tt%0d", tag, i), (i == 0) ? tt0 : tt1, (i == 0) ? e0 : e1);
      chk($sformatf("%s_done_cnt%0d", tag, i), done_c[i], full ? 1 : 0);
      chk($sformatf("%s_busy_cnt%0d", tag, i), busy_c[i], full ? len : k);
      if (full) chk($sformatf("%s_done_lat%0d", tag, i), done_n[i], len);
      if (k == 0) begin
        bad = 0;
        for (int v = 0; v < 8; v++) if (hold_c[i][v] != s + 1) bad++;
        chk($sformatf("%s_hold%0d", tag, i), bad, 0);
      end
      chk($sformatf("%s_abc_idle%0d", tag, i),
          (i == 0) ? {a0, b0, c0} : {a1, b1, c1}, 3'b000);
    end
  endtask

  initial begin
    logic [7:0] last_e0, last_e1;
    int k;
    vecs[0] = '{8'hEA, 8'h96, 0,  8'hEA, 8'h96};
    vecs[1] = '{8'hEA, 8'h96, 14, 8'h0A, 8'h16};
    vecs[2] = '{8'h96, 8'hEA, 0,  8'h96, 8'hEA};
    vecs[3] = '{8'hFF, 8'hA5, 24, 8'h7F, 8'hA5};
    vecs[4] = '{8'hFF, 8'hFF, 1,  8'h00, 8'h00};

    rst = 1'b1; start = 1'b0; abort = 1'b0; tab0 = 8'h00; tab1 = 8'h00;
`ifdef TT_COMPARE_EN
    exp0 = 8'h00; exp1 = 8'h00;
`endif
    #12;
    chk("reset_outs0", {a0, b0, c0, busy0, done0, tt0}, '0);
    chk("reset_outs1", {a1, b1, c1, busy1, done1, tt1}, '0);
    rst = 1'b0;
    tick();
    chk("post_reset_idle", {busy0, done0, busy1, done1}, 4'b0000);

    for (int r = 0; r < 5; r++) begin
      tab0 = vecs[r].t0;
      tab1 = vecs[r].t1;
`ifdef TT_COMPARE_EN
      exp0 = (r == 0) ? 8'hEB : vecs[r].t0;
      exp1 = (r == 0) ? 8'h96 : 8'h97;
`endif
      run_scan(vecs[r].k);
      verify($sformatf("vec%0d", r), vecs[r].k, vecs[r].e0, vecs[r].e1);
`ifdef TT_COMPARE_EN
      if (r == 0) begin
        chk("cmp_pass1", pass1, 1'b1);
        chk("cmp_mm1", mm1, 8'h00);
        chk("cmp_pass0", pass0, 1'b0);
        chk("cmp_mm0", mm0, 8'h01);
      end
`endif
    end

    for (int r = 0; r < 8; r++) begin
      tab0 = 8'($urandom);
      tab1 = 8'($urandom);
      k = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 30));
      run_scan(k);
      last_e0 = model_tt(tab0, 2, k);
      last_e1 = model_tt(tab1, 1, k);
      verify($sformatf("rnd%0d", r), k, last_e0, last_e1);
    end

    // start together with abort in IDLE must not launch a scan or touch tt
    start = 1'b1; abort = 1'b1;
    tick();
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", {busy0, busy1}, 2'b00);
    chk("abort_start_tt0", tt0, last_e0);
    chk("abort_start_tt1", tt1, last_e1);

    // start held high: ignored while busy/DONE, re-accepted from IDLE; then reset mid-scan
    tab0 = 8'hFF; tab1 = 8'hFF;
    start = 1'b1;
    tick();
    done_n[0] = -1;
    for (int n = 0; n < 30; n++) begin
      if (done0 && done_n[0] < 0) done_n[0] = n;
      if (n == 25) chk("held_start_idle", busy0, 1'b0);
      if (n == 26) chk("held_start_restart", busy0, 1'b1);
      tick();
    end
    chk("held_start_done_lat", done_n[0], 24);
    chk("pre_rst_tt0", tt0, 8'h01);
    chk("pre_rst_tt1", tt1, 8'h3F);
    #2 rst = 1'b1;
    #1;
    chk("midscan_rst0", {a0, b0, c0, busy0, done0, tt0}, '0);
    chk("midscan_rst1", {a1, b1, c1, busy1, done1, tt1}, '0);
    #2 rst = 1'b0;
    tick();
    chk("first_edge_after_rst", {busy0, busy1}, 2'b11);
    start = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
